minimig_sram_ctrl: RTL and testbench

- Parametrised, clocked successor to the combinational chipset-to-SRAM bridge.
- Accepts single-word requests on a req/ack handshake and maps a one-hot bank select plus bus address onto an external asynchronous SRAM address.
- Sequences _ce/_oe/_we/byte-enables and the data buffer enable through programmable setup, strobe and hold phases.
- Sits between the chipset/CPU arbiter and the board SRAM pins, replacing fixed c1/c3 timing with counted wait states.

---
 rtl/minimig_sram_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_minimig_sram_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/minimig_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : minimig_sram_ctrl
// Purpose  : Clocked chipset/CPU-to-SRAM bridge. Accepts one word request on
//            a req/ack handshake. Maps a one-hot bank select plus bus address
//            onto the external SRAM address. Sequences _ce/_oe/_we, the byte
//            enables and the data buffer enable through counted setup, strobe
//            and hold phases.
// Revision : 1.0 - initial clocked implementation
// ----------------------------------------------------------------------------
// Ports:
//   clk         in   system clock
//   _reset      in   asynchronous active-low reset
//   req         in   access request (level, sampled in IDLE)
//   wr          in   1 = write, 0 = read (sampled with req)
//   be          in   byte enables, active high (sampled with req)
//   bank        in   one-hot bank select (lowest set bit wins)
//   address_in  in   bus address [23:1]
//   data_in     in   write data (sampled with req)
//   data_out    out  registered read data, masked per byte lane
//   ack         out  one-cycle completion pulse
//   busy        out  high from acceptance until ack inclusive
//   _ce/_oe/_we out  SRAM strobes, active low
//   _be         out  SRAM byte enables, active low (lane 0 = _ble)
//   address     out  SRAM word address [ADDR_W:1]
//   data        out  registered SRAM write data
//   data_oe     out  SRAM data bus buffer enable (writes only)
//   ramdata_in  in   SRAM read data
// ============================================================================
module minimig_sram_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 22,
  parameter int NUM_BANKS = 8,
  parameter logic [NUM_BANKS*(ADDR_W-18)-1:0] BANK_MAP =
    {4'd7, 4'd0, 4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0},
  parameter logic [NUM_BANKS-1:0] PASS_MASK = 8'b0001_0000,
  parameter int T_SETUP   = 1,
  parameter int T_RD      = 2,
  parameter int T_WR      = 2,
  parameter int T_HOLD    = 1
) (
  input  logic                   clk,
  input  logic                   _reset,
  input  logic                   req,
  input  logic                   wr,
  input  logic [DATA_W/8-1:0]    be,
  input  logic [NUM_BANKS-1:0]   bank,
  input  logic [23:1]            address_in,
  input  logic [DATA_W-1:0]      data_in,
  output logic [DATA_W-1:0]      data_out,
  output logic                   ack,
  output logic                   busy,
  output logic                   _ce,
  output logic                   _oe,
  output logic                   _we,
  output logic [DATA_W/8-1:0]    _be,
  output logic [ADDR_W:1]        address,
  output logic [DATA_W-1:0]      data,
  output logic                   data_oe,
  input  logic [DATA_W-1:0]      ramdata_in
);

  localparam int NB    = DATA_W / 8;
  localparam int HI_W  = ADDR_W - 18;
  localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  localparam int T_MAX01 = (T_SETUP > T_RD)   ? T_SETUP : T_RD;
  localparam int T_MAX23 = (T_WR > T_HOLD)    ? T_WR    : T_HOLD;
  localparam int T_MAX   = (T_MAX01 > T_MAX23) ? T_MAX01 : T_MAX23;
  localparam int CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] C_RD    = CNT_W'(T_RD - 1);
  localparam logic [CNT_W-1:0] C_WR    = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'((T_HOLD > 0) ? T_HOLD - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              wr_r, wr_nxt;
  logic [NB-1:0]     be_r, be_nxt;
  logic              accept, unmapped, capture, active_nxt;

  // --------------------------------------------------------------------------
  // Address mapping: lowest set bank bit selects the high address source.
  // address_in is re-based to bit 0 so address_in[k] sits at ain_ext[k-1].
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] ain_ext;
  logic [IDX_W-1:0]  sel;
  logic [HI_W-1:0]   hi;
  logic [ADDR_W-1:0] addr_nxt;

  assign ain_ext = ADDR_W'(address_in);

  always_comb begin
    sel = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (bank[i]) sel = IDX_W'(i);
    end
  end

  assign hi       = PASS_MASK[sel] ? ain_ext[ADDR_W-1:18]
                                   : BANK_MAP[int'(sel)*HI_W +: HI_W];
  assign addr_nxt = {hi, ain_ext[17:0]};

  // Read data masked per lane; disabled lanes return zero.
  logic [DATA_W-1:0] rd_masked;
  generate
    for (genvar g = 0; g < NB; g++) begin : g_lane
      assign rd_masked[8*g +: 8] = be_r[g] ? ramdata_in[8*g +: 8] : 8'h00;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM: state and counter register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      wr_r  <= 1'b0;
      be_r  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      wr_r  <= wr_nxt;
      be_r  <= be_nxt;
    end
  end

  // FSM: next state, counter and latched request attributes
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_nxt    = wr_r;
    be_nxt    = be_r;
    accept    = 1'b0;
    unmapped  = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          wr_nxt = wr;
          be_nxt = be;
          if (bank != '0) begin
            accept    = 1'b1;
            state_nxt = S_SETUP;
            cnt_nxt   = C_SETUP;
          end else begin
            unmapped  = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_nxt = S_STROBE;
          cnt_nxt   = wr_r ? C_WR : C_RD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (cnt == '0) begin
          capture = !wr_r;
          if (T_HOLD > 0) begin
            state_nxt = S_HOLD;
            cnt_nxt   = C_HOLD;
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt == '0) state_nxt = S_DONE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // CE, byte enables and buffer enable span SETUP..HOLD.
  assign active_nxt = (state_nxt == S_SETUP) || (state_nxt == S_STROBE) ||
                      (state_nxt == S_HOLD);

  // --------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so every pin changes
  // on the same edge as the state it belongs to.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      _ce      <= 1'b1;
      _oe      <= 1'b1;
      _we      <= 1'b1;
      _be      <= '1;
      data_oe  <= 1'b0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      data_out <= '0;
      address  <= '0;
      data     <= '0;
    end else begin
      _ce     <= !active_nxt;
      _oe     <= !((state_nxt == S_STROBE) && !wr_nxt);
      _we     <= !((state_nxt == S_STROBE) &&  wr_nxt);
      _be     <= active_nxt ? ~be_nxt : '1;
      data_oe <= active_nxt && wr_nxt;
      ack     <= (state_nxt == S_DONE);
      busy    <= (state_nxt != S_IDLE);
      if (accept) begin
        address <= addr_nxt;
        data    <= data_in;
      end
      if (unmapped)     data_out <= '0;
      else if (capture) data_out <= rd_masked;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_minimig_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_minimig_sram_ctrl
// Purpose  : Self-checking bench for minimig_sram_ctrl. Table of directed
//            accesses with hand-computed results, plus sequences for reset
//            during a write and back-to-back accesses with other timings.
// Revision : 1.0 - initial bench
// ============================================================================
module tb_minimig_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, req2 = 1'b0, wr = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [7:0]  bank = 8'h00;
  logic [23:1] address_in = '0;
  logic [15:0] data_in = '0, ramdata_in = '0;

  logic [15:0] data_out, data, data_out2, data2;
  logic        ack, busy, ce_n, oe_n, we_n, data_oe;
  logic        ack2, busy2, ce_n2, oe_n2, we_n2, data_oe2;
  logic [1:0]  be_n, be_n2;
  logic [22:1] address, address2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  minimig_sram_ctrl dut (
    .clk(clk), ._reset(rst_n), .req(req), .wr(wr), .be(be), .bank(bank),
    .address_in(address_in), .data_in(data_in), .data_out(data_out),
    .ack(ack), .busy(busy), ._ce(ce_n), ._oe(oe_n), ._we(we_n), ._be(be_n),
    .address(address), .data(data), .data_oe(data_oe),
    .ramdata_in(ramdata_in)
  );

  minimig_sram_ctrl #(.T_SETUP(2), .T_RD(1), .T_HOLD(0)) dut2 (
    .clk(clk), ._reset(rst_n), .req(req2), .wr(wr), .be(be), .bank(bank),
    .address_in(address_in), .data_in(data_in), .data_out(data_out2),
    .ack(ack2), .busy(busy2), ._ce(ce_n2), ._oe(oe_n2), ._we(we_n2),
    ._be(be_n2), .address(address2), .data(data2), .data_oe(data_oe2),
    .ramdata_in(ramdata_in)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  be;
    logic [7:0]  bank;
    logic [23:1] ain;
    logic [15:0] din;
    logic [15:0] rdata;
    logic [22:1] exp_addr;
    logic [15:0] exp_dout;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  // One access: request for one cycle, then scramble the request inputs
  // (they must be ignored while busy) and observe the pins until ack.
  task automatic run_access(input int idx, input vec_t v);
    int n = 0, ce_c = 0, oe_c = 0, we_c = 0, doe_c = 0, be_bad = 0, ovl = 0;
    bit got = 0;
    bit mapped = (v.bank != 8'h00);
    @(negedge clk);
    req = 1'b1; wr = v.wr; be = v.be; bank = v.bank; address_in = v.ain;
    data_in = v.din; ramdata_in = v.rdata;
    while (!got && n < 40) begin
      @(negedge clk);
      if (n == 0) begin
        req = 1'b0; wr = ~v.wr; be = ~v.be; data_in = ~v.din;
        address_in = ~v.ain;
      end
      n++;
      if (!ce_n) ce_c++;
      if (!oe_n) oe_c++;
      if (!we_n) we_c++;
      if (data_oe) doe_c++;
      if (!oe_n && !we_n) ovl++;
      if (!ce_n && be_n !== ~v.be) be_bad++;
      if (ack) got = 1;
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL v%0d ack_timeout: got no ack, expected ack", idx);
    end
    check($sformatf("v%0d latency", idx), n, v.exp_lat);
    check($sformatf("v%0d ce_low_cycles", idx), ce_c, mapped ? 4 : 0);
    check($sformatf("v%0d oe_low_cycles", idx), oe_c, (mapped && !v.wr) ? 2 : 0);
    check($sformatf("v%0d we_low_cycles", idx), we_c, (mapped && v.wr) ? 2 : 0);
    check($sformatf("v%0d data_oe_cycles", idx), doe_c, (mapped && v.wr) ? 4 : 0);
    check($sformatf("v%0d be_n_errors", idx), be_bad, 0);
    check($sformatf("v%0d oe_we_overlap", idx), ovl, 0);
    check($sformatf("v%0d busy_at_ack", idx), busy, 1);
    check($sformatf("v%0d data_out", idx), data_out, v.exp_dout);
    if (mapped) check($sformatf("v%0d address", idx), address, v.exp_addr);
    if (mapped && v.wr) check($sformatf("v%0d data", idx), data, v.din);
    @(negedge clk);
    check($sformatf("v%0d ack_after", idx), ack, 0);
    check($sformatf("v%0d busy_after", idx), busy, 0);
  endtask

  initial begin
    //          wr    be     bank          ain          din       rdata     exp_addr      exp_dout  lat
    vecs[0] = '{1'b0, 2'b11, 8'b0000_0001, 23'h000123, 16'h0000, 16'hBEEF, 22'h000123, 16'hBEEF, 5};
    vecs[1] = '{1'b1, 2'b10, 8'b0000_0001, 23'h000456, 16'h1234, 16'h0000, 22'h000456, 16'hBEEF, 5};
    vecs[2] = '{1'b0, 2'b01, 8'b0001_0000, 23'h640ABC, 16'h0000, 16'hCAFE, 22'h240ABC, 16'h00FE, 5};
    vecs[3] = '{1'b0, 2'b10, 8'b1000_0000, 23'h7FFFFF, 16'h0000, 16'h5A5A, 22'h1FFFFF, 16'h5A00, 5};
    vecs[4] = '{1'b0, 2'b11, 8'b0000_0000, 23'h000777, 16'h0000, 16'h9999, 22'h000000, 16'h0000, 1};
    vecs[5] = '{1'b0, 2'b11, 8'b0000_0110, 23'h012345, 16'h0000, 16'h1111, 22'h052345, 16'h1111, 5};
    vecs[6] = '{1'b1, 2'b11, 8'b0000_1000, 23'h000001, 16'hABCD, 16'h0000, 22'h0C0001, 16'h1111, 5};
    vecs[7] = '{1'b0, 2'b11, 8'b0100_0000, 23'h7C0002, 16'h0000, 16'h0F0F, 22'h000002, 16'h0F0F, 5};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst ce_n", ce_n, 1);
    check("rst oe_n", oe_n, 1);
    check("rst we_n", we_n, 1);
    check("rst be_n", be_n, 2'b11);
    check("rst data_oe", data_oe, 0);
    check("rst ack", ack, 0);
    check("rst busy", busy, 0);
    check("rst data_out", data_out, 0);
    check("rst address", address, 0);
    check("rst data", data, 0);
    rst_n = 1'b1;

    // ---- reset during a write strobe ----
    begin
      int w = 0;
      int acks = 0;
      @(negedge clk);
      req = 1'b1; wr = 1'b1; be = 2'b11; bank = 8'h01;
      address_in = 23'h000042; data_in = 16'h5555;
      @(negedge clk);
      req = 1'b0;
      while (we_n && w < 10) begin
        @(negedge clk);
        w++;
      end
      check("midrst we_low_seen", we_n, 0);
      check("midrst data_oe_before", data_oe, 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst we_n", we_n, 1);
      check("midrst ce_n", ce_n, 1);
      check("midrst data_oe", data_oe, 0);
      check("midrst busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (ack) acks++;
      end
      check("midrst no_ack", acks, 0);
      check("midrst ce_n_after", ce_n, 1);
    end

    // ---- table-driven accesses ----
    for (int i = 0; i < 8; i++) run_access(i, vecs[i]);

    // ---- back-to-back reads on the T_SETUP=2/T_RD=1/T_HOLD=0 instance ----
    begin
      int ack_at[$];
      int oe_c = 0;
      int ovl = 0;
      @(negedge clk);
      wr = 1'b0; be = 2'b11; bank = 8'h01; address_in = 23'h000010;
      ramdata_in = 16'h7777; req2 = 1'b1;
      for (int k = 1; k <= 14; k++) begin
        @(negedge clk);
        if (ack2) ack_at.push_back(k);
        if (!oe_n2) oe_c++;
        if (!oe_n2 && !we_n2) ovl++;
        if (k == 5) check("b2b idle_busy", busy2, 0);
      end
      req2 = 1'b0;
      check("b2b ack_count", ack_at.size(), 3);
      if (ack_at.size() == 3) begin
        check("b2b ack0", ack_at[0], 4);
        check("b2b ack1", ack_at[1], 9);
        check("b2b ack2", ack_at[2], 14);
      end
      check("b2b oe_low_cycles", oe_c, 3);
      check("b2b overlap", ovl, 0);
      check("b2b data_out", data_out2, 16'h7777);
      check("b2b dut1_untouched", data_out, 16'h0F0F);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
